// File: rtl/thirtytwo_to_ten_leds.sv
// Purpose: shows a 32-bit word one byte at a time on ten LEDs as {byte index, byte}.
// Latency: load/step act on the 3rd rising clk edge after the input rises; out is combinational from registers.
// Backpressure: none; events are edge-detected, so a held level yields exactly one event.
module thirtytwo_to_ten_leds #(
    parameter int AUTO_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in,
    input  logic        load,
    input  logic        step,
    input  logic        auto,
    output logic [9:0]  out,
    output logic        done
);

    localparam int DIV_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(AUTO_DIV - 1);

    // [0],[1] form the metastability synchronizer; [2] is the previous synchronized level
    logic [2:0]       load_sync;
    logic [2:0]       step_sync;
    logic [31:0]      hold;
    logic [1:0]       idx;
    logic [DIV_W-1:0] div;

    logic load_evt;
    logic step_evt;
    logic adv_evt;

    assign load_evt = load_sync[1] & ~load_sync[2];
    assign step_evt = step_sync[1] & ~step_sync[2];
    // a step during auto mode is a single advance that also restarts the timer
    assign adv_evt  = step_evt | (auto & (div == DIV_MAX));

    // synchronize the asynchronous buttons and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sync <= 3'b000;
            step_sync <= 3'b000;
        end else begin
            load_sync <= {load_sync[1:0], load};
            step_sync <= {step_sync[1:0], step};
        end
    end

    // display state: load has priority over any advance in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= 32'h0;
            idx  <= 2'd0;
            div  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_evt) begin
                hold <= in;
                idx  <= 2'd0;
                div  <= '0;
            end else if (adv_evt) begin
                idx  <= idx + 2'd1;
                div  <= '0;
                done <= (idx == 2'd3);
            end else if (auto) begin
                div  <= div + 1'b1;
            end else begin
                div  <= '0;
            end
        end
    end

    // idx 0 selects bits 7:0, idx 3 selects bits 31:24
    assign out = {idx, hold[{idx, 3'b000} +: 8]};

endmodule
